// File: rtl/pixel_block_loader.sv
// rtl/pixel_block_loader.sv - gathers NUM_PIX pixels into one packed block and holds it for a downstream stage
module pixel_block_loader #(
    parameter int NUM_PIX = 16,
    parameter int PIX_W   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [PIX_W-1:0]               pix_data,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    output logic [NUM_PIX*PIX_W-1:0]       block_data,
    output logic                           block_valid,
    input  logic                           block_ack,
    output logic                           busy,
    output logic [$clog2(NUM_PIX+1)-1:0]   pix_count,
    output logic                           overrun_err
);

    localparam int CW = $clog2(NUM_PIX + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_PIX - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    // Handshake outputs decode straight from the state register, so they carry no combinational input paths.
    assign pix_ready   = (state == FILL);
    assign block_valid = (state == HOLD);
    assign busy        = (state == FILL) || (state == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pix_count   <= '0;
            block_data  <= '0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        pix_count <= '0;
                    end
                end
                FILL: begin
                    if (start) begin
                        overrun_err <= 1'b1;
                    end
                    if (pix_valid) begin
                        for (int i = 0; i < NUM_PIX; i++) begin
                            if (pix_count == CW'(i)) begin
                                block_data[PIX_W*i +: PIX_W] <= pix_data;
                            end
                        end
                        pix_count <= pix_count + CW'(1);
                        if (pix_count == LAST_SLOT) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // ack with start chains straight into the next block without an idle cycle.
                    if (block_ack) begin
                        if (start) begin
                            state     <= FILL;
                            pix_count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (start) begin
                        overrun_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pixel_block_loader.md
PIXEL_BLOCK_LOADER -- requirements
Module: pixel_block_loader

Interface
REQ-001 SHALL have parameter NUM_PIX, default 16, number of pixel slots per block.
REQ-002 SHALL have parameter PIX_W, default 8, bits per pixel.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to capture a new block.
REQ-006 SHALL have port pix_data  input  PIX_W  incoming pixel value.
REQ-007 SHALL have port pix_valid  input  1  pix_data valid this cycle.
REQ-008 SHALL have port pix_ready  output  1  block can accept a pixel this cycle.
REQ-009 SHALL have port block_data  output  NUM_PIX*PIX_W  packed block; slot i at bits [PIX_W*i+PIX_W-1 : PIX_W*i].
REQ-010 SHALL have port block_valid  output  1  complete block presented to the downstream per-pixel stage.
REQ-011 SHALL have port block_ack  input  1  downstream has consumed block_data.
REQ-012 SHALL have port busy  output  1  high in FILL or HOLD.
REQ-013 SHALL have port pix_count  output  $clog2(NUM_PIX+1)  pixels accepted into the current block.
REQ-014 SHALL have port overrun_err  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL implement states IDLE, FILL and HOLD; all outputs registered or decoded from registered state only.
REQ-016 In IDLE, start SHALL move the block to FILL next cycle, with pix_count cleared to 0.
REQ-017 In FILL, pix_ready SHALL be 1; in IDLE and HOLD, pix_ready SHALL be 0.
REQ-018 A beat SHALL be accepted only when pix_valid and pix_ready are both 1; pix_data is then written to slot pix_count and pix_count increments by 1.
REQ-019 Slots are filled in arrival order 0..NUM_PIX-1; no other slot changes on an accept.
REQ-020 On acceptance of beat NUM_PIX-1, the state SHALL become HOLD, and block_valid SHALL be 1 from the next cycle (latency 1 cycle after the last accepted beat); pix_count reads NUM_PIX in HOLD.
REQ-021 In HOLD, block_data SHALL remain stable and block_valid SHALL stay 1 until block_ack is sampled high.
REQ-022 block_ack in HOLD without start SHALL return the block to IDLE; block_valid SHALL be 0 next cycle; block_data keeps its last contents.
REQ-023 block_ack and start together in HOLD SHALL go directly to FILL with pix_count=0 (back-to-back blocks, no IDLE cycle).
REQ-024 start in FILL, or start in HOLD without block_ack, SHALL be ignored for control and SHALL set overrun_err.
REQ-025 overrun_err SHALL be cleared only by rst.
REQ-026 pix_valid in IDLE or HOLD SHALL be ignored: no write and no count change.
REQ-027 block_ack outside HOLD SHALL be ignored.
REQ-028 Pixel gaps (pix_valid low) in FILL SHALL hold state and count with no timeout.
REQ-029 Old slot contents SHALL persist in block_data until overwritten by the next block.

Reset
REQ-030 While rst is high, the block SHALL force state IDLE, pix_count 0, block_valid 0, pix_ready 0, busy 0, overrun_err 0, and all block_data slots 0, independent of clk.
REQ-031 rst asserted mid-FILL or in HOLD SHALL discard the partial or held block; the first cycle after deassertion SHALL be IDLE.

Verification
REQ-032 Basic fill: rst, start, then 16 consecutive beats 0x00..0x0F -> block_valid=1 one cycle after beat 15; block_data=0x0F0E...0100; pix_ready=0 in HOLD.
REQ-033 Gapped fill: beats 0xA0..0xAF with pix_valid low every other cycle -> same result order; pix_count steps only on accepted beats.
REQ-034 Back-to-back: in HOLD, assert block_ack and start together, then send 16 beats of 0x55 -> FILL next cycle with no IDLE; second block_data is all 0x55.
REQ-035 Violations: start at pix_count=5 in FILL, and pix_valid in HOLD -> overrun_err=1 stays set; fill continues from slot 5; the HOLD beat is not written.
REQ-036 Reset mid-operation: rst asserted asynchronously at pix_count=9 -> all outputs 0 immediately; after release, start plus 16 beats yields a correct fresh block.
